// File: rtl/frame_read_pkg.sv
// Shared types and helpers for the frame reader: FSM state encoding and burst sizing.
package frame_read_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StAck      = 3'd1,
    StCheck    = 3'd2,
    StBurst    = 3'd3,
    StBurstEnd = 3'd4,
    StEnd      = 3'd5
  } state_t;

  // FIFO-space compare is done at this width so a 16-bit count plus a burst cannot overflow.
  localparam int unsigned FifoCmpBits = 17;

  function automatic logic [31:0] min_len(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_read_dma_if.sv
// Burst-read port between the frame reader (master) and the memory controller (slave).
interface frame_read_dma_if #(
  parameter int unsigned ADDR_BITS  = 23,
  parameter int unsigned BURST_BITS = 10
) ();

  logic                  rd_burst_req;
  logic [BURST_BITS-1:0] rd_burst_len;
  logic [ADDR_BITS-1:0]  rd_burst_addr;
  logic                  rd_burst_data_valid;
  logic                  rd_burst_finish;

  modport master (
    output rd_burst_req,
    output rd_burst_len,
    output rd_burst_addr,
    input  rd_burst_data_valid,
    input  rd_burst_finish
  );

  modport slave (
    input  rd_burst_req,
    input  rd_burst_len,
    input  rd_burst_addr,
    output rd_burst_data_valid,
    output rd_burst_finish
  );

endinterface

// File: rtl/frame_req_sync.sv
// Two-flop level synchroniser with synchronous active-low reset.
module frame_req_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/frame_read_dma.sv
// Frame reader: splits one frame into FIFO-throttled burst reads, restartable by a new request.
module frame_read_dma
  import frame_read_pkg::*;
#(
  parameter int unsigned MEM_DATA_BITS = 32,
  parameter int unsigned ADDR_BITS     = 23,
  parameter int unsigned BURST_BITS    = 10,
  parameter int unsigned BURST_SIZE    = 256,
  parameter int unsigned FIFO_DEPTH    = 512,
  parameter int unsigned NUM_BUF       = 4,
  localparam int unsigned IDX_BITS     = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
  input  logic                         i_mem_clk,
  input  logic                         i_rst_n,
  input  logic                         i_read_req,
  output logic                         o_read_req_ack,
  output logic                         o_read_finish,
  output logic                         o_busy,
  input  logic [NUM_BUF*ADDR_BITS-1:0] i_read_addr,
  input  logic [IDX_BITS-1:0]          i_read_addr_index,
  input  logic [ADDR_BITS-1:0]         i_read_len,
  frame_read_dma_if.master             mem_if,
  output logic                         o_fifo_aclr,
  input  logic [15:0]                  i_wr_data_count
);

  logic w_req_s;

  frame_req_sync u_req_sync (
    .i_clk   (i_mem_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_read_req),
    .o_q     (w_req_s)
  );

  state_t                r_state,      w_state_next;
  logic                  r_ack,        w_ack_next;
  logic                  r_aclr,       w_aclr_next;
  logic                  r_burst_req,  w_burst_req_next;
  logic [BURST_BITS-1:0] r_burst_len,  w_burst_len_next;
  logic [ADDR_BITS-1:0]  r_burst_addr, w_burst_addr_next;
  logic [ADDR_BITS-1:0]  r_len_latch,  w_len_latch_next;
  logic [ADDR_BITS-1:0]  r_read_cnt,   w_read_cnt_next;

  logic [ADDR_BITS-1:0]   w_base;
  logic [ADDR_BITS-1:0]   w_remain;
  logic [ADDR_BITS-1:0]   w_cur_len;
  logic [FifoCmpBits-1:0] w_fifo_need;
  logic                   w_fits;
  logic                   w_unused_cfg;

  assign w_unused_cfg = (MEM_DATA_BITS != 0);
  assign w_base       = i_read_addr[32'(i_read_addr_index) * ADDR_BITS +: ADDR_BITS];
  assign w_remain     = r_len_latch - r_read_cnt;
  assign w_cur_len    = ADDR_BITS'(min_len(32'(w_remain), 32'(BURST_SIZE)));
  // Throttle against the real burst length so a short final burst is not held back.
  assign w_fifo_need  = FifoCmpBits'(i_wr_data_count) + FifoCmpBits'(w_cur_len);
  assign w_fits       = (w_fifo_need <= FifoCmpBits'(FIFO_DEPTH));

  always_comb begin
    w_state_next      = r_state;
    w_ack_next        = r_ack;
    w_aclr_next       = r_aclr;
    w_burst_req_next  = r_burst_req;
    w_burst_len_next  = r_burst_len;
    w_burst_addr_next = r_burst_addr;
    w_len_latch_next  = r_len_latch;
    w_read_cnt_next   = r_read_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_req_s) w_state_next = StAck;
      end
      StAck: begin
        if (w_req_s) begin
          w_ack_next        = 1'b1;
          w_aclr_next       = 1'b1;
          w_burst_addr_next = w_base;
          w_len_latch_next  = i_read_len;
          w_read_cnt_next   = '0;
        end else begin
          w_ack_next   = 1'b0;
          w_aclr_next  = 1'b0;
          w_state_next = (r_len_latch == '0) ? StEnd : StCheck;
        end
      end
      StCheck: begin
        if (w_req_s) begin
          w_state_next = StAck;
        end else if (w_fits) begin
          w_burst_len_next = BURST_BITS'(w_cur_len);
          w_burst_req_next = 1'b1;
          w_state_next     = StBurst;
        end
      end
      StBurst: begin
        if (mem_if.rd_burst_data_valid) w_burst_req_next = 1'b0;
        if (mem_if.rd_burst_finish) begin
          w_read_cnt_next   = r_read_cnt + ADDR_BITS'(r_burst_len);
          w_burst_addr_next = r_burst_addr + ADDR_BITS'(r_burst_len);
          w_state_next      = StBurstEnd;
        end
      end
      StBurstEnd: begin
        if (w_req_s)                        w_state_next = StAck;
        else if (r_read_cnt < r_len_latch)  w_state_next = StCheck;
        else                                w_state_next = StEnd;
      end
      StEnd: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_mem_clk) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_ack        <= 1'b0;
      r_aclr       <= 1'b0;
      r_burst_req  <= 1'b0;
      r_burst_len  <= '0;
      r_burst_addr <= '0;
      r_len_latch  <= '0;
      r_read_cnt   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_ack        <= w_ack_next;
      r_aclr       <= w_aclr_next;
      r_burst_req  <= w_burst_req_next;
      r_burst_len  <= w_burst_len_next;
      r_burst_addr <= w_burst_addr_next;
      r_len_latch  <= w_len_latch_next;
      r_read_cnt   <= w_read_cnt_next;
    end
  end

  assign o_read_req_ack       = r_ack;
  assign o_fifo_aclr          = r_aclr;
  assign o_busy               = (r_state != StIdle);
  assign o_read_finish        = (r_state == StEnd);
  assign mem_if.rd_burst_req  = r_burst_req;
  assign mem_if.rd_burst_len  = r_burst_len;
  assign mem_if.rd_burst_addr = r_burst_addr;

endmodule

// File: tb/tb_frame_read_dma.sv
// Self-checking bench for frame_read_dma: table of frames, directed corner sequences, random frames.
module tb_frame_read_dma;

  localparam int unsigned AW = 23;
  localparam int unsigned BS = 256;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [9:0]    len;
  } burst_t;

  typedef struct {
    int            idx;
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    int            exp_n;
    int            exp_last_len;
    logic [AW-1:0] exp_addr1;
  } vec_t;

  logic            clk;
  logic            rst_n;
  logic            read_req;
  logic            read_req_ack;
  logic            read_finish;
  logic            busy;
  logic [4*AW-1:0] read_addr;
  logic [1:0]      read_addr_index;
  logic [AW-1:0]   read_len;
  logic            fifo_aclr;
  logic [15:0]     wr_data_count;

  frame_read_dma_if #(.ADDR_BITS(AW), .BURST_BITS(10)) mem_if ();

  frame_read_dma dut (
    .i_mem_clk         (clk),
    .i_rst_n           (rst_n),
    .i_read_req        (read_req),
    .o_read_req_ack    (read_req_ack),
    .o_read_finish     (read_finish),
    .o_busy            (busy),
    .i_read_addr       (read_addr),
    .i_read_addr_index (read_addr_index),
    .i_read_len        (read_len),
    .mem_if            (mem_if),
    .o_fifo_aclr       (fifo_aclr),
    .i_wr_data_count   (wr_data_count)
  );

  int     n_checks = 0;
  int     n_fail = 0;
  int     finish_cnt = 0;
  bit     ctrl_en = 1'b1;
  int     ctrl_delay_min = 0;
  burst_t got[$];
  burst_t exp_q[$];
  vec_t   vecs[6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial forever begin
    @(negedge clk);
    if (read_finish) finish_cnt++;
  end

  // Memory controller model: accepts a burst, returns a few beats, then signals finish.
  initial begin
    mem_if.rd_burst_data_valid = 1'b0;
    mem_if.rd_burst_finish     = 1'b0;
    forever begin
      @(negedge clk);
      mem_if.rd_burst_data_valid = 1'b0;
      mem_if.rd_burst_finish     = 1'b0;
      if (ctrl_en && rst_n && mem_if.rd_burst_req) begin
        int nb;
        bit same;
        got.push_back('{addr: mem_if.rd_burst_addr, len: mem_if.rd_burst_len});
        repeat ($urandom_range(ctrl_delay_min, ctrl_delay_min + 2)) @(negedge clk);
        nb   = $urandom_range(1, 4);
        same = 1'($urandom_range(0, 1));
        for (int b = 0; b < nb; b++) begin
          mem_if.rd_burst_data_valid = 1'b1;
          mem_if.rd_burst_finish     = same && (b == nb - 1);
          @(negedge clk);
          mem_if.rd_burst_data_valid = 1'b0;
          mem_if.rd_burst_finish     = 1'b0;
        end
        if (!same) begin
          mem_if.rd_burst_finish = 1'b1;
          @(negedge clk);
          mem_if.rd_burst_finish = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Expected burst list derived directly from the frame rules.
  task automatic model_bursts(input logic [AW-1:0] base, input logic [AW-1:0] len);
    int rem = int'(len);
    int a   = int'(base);
    while (rem > 0) begin
      int l = (rem > BS) ? BS : rem;
      exp_q.push_back('{addr: AW'(a), len: 10'(l)});
      a   = (a + l) % (1 << AW);
      rem = rem - l;
    end
  endtask

  task automatic compare_bursts(input string name);
    check({name, "_nbursts"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      check({name, "_addr"}, 32'(got[i].addr), 32'(exp_q[i].addr));
      check({name, "_len"}, 32'(got[i].len), 32'(exp_q[i].len));
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ack"}, 32'(read_req_ack), 0);
    check({name, "_finish"}, 32'(read_finish), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_aclr"}, 32'(fifo_aclr), 0);
    check({name, "_breq"}, 32'(mem_if.rd_burst_req), 0);
    check({name, "_blen"}, 32'(mem_if.rd_burst_len), 0);
    check({name, "_baddr"}, 32'(mem_if.rd_burst_addr), 0);
  endtask

  task automatic prep_frame();
    got.delete();
    exp_q.delete();
    finish_cnt = 0;
  endtask

  task automatic set_inputs(input int idx, input logic [AW-1:0] base, input logic [AW-1:0] len);
    for (int k = 0; k < 4; k++) read_addr[k*AW +: AW] = AW'($urandom);
    read_addr[idx*AW +: AW] = base;
    read_addr_index         = 2'(idx);
    read_len                = len;
  endtask

  task automatic wait_ack(input string name);
    int t = 0;
    while (!read_req_ack && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({name, "_ack_seen"}, 32'(read_req_ack), 1);
    check({name, "_aclr_with_ack"}, 32'(fifo_aclr), 1);
  endtask

  task automatic start_frame(input string name, input int idx, input logic [AW-1:0] base,
                             input logic [AW-1:0] len);
    set_inputs(idx, base, len);
    read_req = 1'b1;
    wait_ack(name);
    read_req = 1'b0;
  endtask

  task automatic finish_frame(input string name);
    int t = 0;
    while (finish_cnt == 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check({name, "_finish_pulses"}, finish_cnt, 1);
    check({name, "_idle_after"}, 32'(busy), 0);
    compare_bursts(name);
  endtask

  initial begin
    rst_n           = 1'b0;
    read_req        = 1'b0;
    read_addr       = '0;
    read_addr_index = '0;
    read_len        = '0;
    wr_data_count   = '0;

    vecs[0] = '{idx: 2, base: 23'h001000, len: 23'd600, exp_n: 3, exp_last_len: 88,
                exp_addr1: 23'h001100};
    vecs[1] = '{idx: 0, base: 23'h000020, len: 23'd512, exp_n: 2, exp_last_len: 256,
                exp_addr1: 23'h000120};
    vecs[2] = '{idx: 1, base: 23'h000500, len: 23'd0, exp_n: 0, exp_last_len: 0,
                exp_addr1: 23'h0};
    vecs[3] = '{idx: 3, base: 23'h7FFF00, len: 23'd512, exp_n: 2, exp_last_len: 256,
                exp_addr1: 23'h000000};
    vecs[4] = '{idx: 2, base: 23'h000040, len: 23'd1, exp_n: 1, exp_last_len: 1,
                exp_addr1: 23'h0};
    vecs[5] = '{idx: 1, base: 23'h7FFFFF, len: 23'd257, exp_n: 2, exp_last_len: 1,
                exp_addr1: 23'h0000FF};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Request timing: raised before edge 0.
    prep_frame();
    set_inputs(2, 23'h001000, 23'd600);
    read_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t_edge1_busy", 32'(busy), 0);
    @(negedge clk);
    check("t_edge2_busy", 32'(busy), 1);
    check("t_edge2_ack", 32'(read_req_ack), 0);
    @(negedge clk);
    check("t_edge3_ack", 32'(read_req_ack), 1);
    check("t_edge3_aclr", 32'(fifo_aclr), 1);
    read_req = 1'b0;
    @(negedge clk);
    check("t_fall1_ack", 32'(read_req_ack), 1);
    @(negedge clk);
    check("t_fall2_ack", 32'(read_req_ack), 1);
    @(negedge clk);
    check("t_fall3_ack", 32'(read_req_ack), 0);
    check("t_fall3_aclr", 32'(fifo_aclr), 0);
    check("t_fall3_breq", 32'(mem_if.rd_burst_req), 0);
    @(negedge clk);
    check("t_first_breq", 32'(mem_if.rd_burst_req), 1);
    model_bursts(23'h001000, 23'd600);
    finish_frame("t_frame");

    for (int v = 0; v < 6; v++) begin
      prep_frame();
      model_bursts(vecs[v].base, vecs[v].len);
      start_frame("vec", vecs[v].idx, vecs[v].base, vecs[v].len);
      finish_frame("vec");
      check("vec_count", got.size(), vecs[v].exp_n);
      if (vecs[v].exp_n > 0 && got.size() == vecs[v].exp_n)
        check("vec_last_len", 32'(got[vecs[v].exp_n-1].len), vecs[v].exp_last_len);
      if (vecs[v].exp_n > 1 && got.size() > 1)
        check("vec_addr1", 32'(got[1].addr), 32'(vecs[v].exp_addr1));
    end

    // FIFO throttle: 300 used blocks a 256 burst; 256 used lets it through next cycle.
    begin
      bit saw_req = 1'b0;
      prep_frame();
      wr_data_count = 16'd300;
      model_bursts(23'h002000, 23'd600);
      start_frame("thr", 1, 23'h002000, 23'd600);
      repeat (12) begin
        @(negedge clk);
        if (mem_if.rd_burst_req) saw_req = 1'b1;
      end
      check("thr_held", 32'(saw_req), 0);
      check("thr_busy", 32'(busy), 1);
      wr_data_count = 16'd256;
      @(negedge clk);
      check("thr_release", 32'(mem_if.rd_burst_req), 1);
      finish_frame("thr");
      wr_data_count = 16'd0;
    end

    // Restart during the second burst: it completes, then the new frame begins.
    begin
      int t = 0;
      prep_frame();
      ctrl_delay_min = 6;
      model_bursts(23'h001000, 23'd512);
      model_bursts(23'h003000, 23'd300);
      start_frame("rst_a", 2, 23'h001000, 23'd600);
      while (got.size() < 2 && t < 2000) begin
        @(negedge clk);
        t++;
      end
      check("restart_second_burst", got.size(), 2);
      start_frame("restart", 0, 23'h003000, 23'd300);
      ctrl_delay_min = 0;
      finish_frame("restart");
    end

    // Reset pulse mid-burst.
    begin
      int t = 0;
      prep_frame();
      ctrl_en = 1'b0;
      start_frame("mid_rst", 3, 23'h004000, 23'd100);
      while (!mem_if.rd_burst_req && t < 40) begin
        @(negedge clk);
        t++;
      end
      check("mid_rst_breq_before", 32'(mem_if.rd_burst_req), 1);
      rst_n = 1'b0;
      @(negedge clk);
      check_all_zero("mid_rst");
      rst_n   = 1'b1;
      ctrl_en = 1'b1;
      @(negedge clk);
      prep_frame();
      model_bursts(23'h004000, 23'd100);
      start_frame("post_rst", 3, 23'h004000, 23'd100);
      finish_frame("post_rst");
    end

    for (int r = 0; r < 10; r++) begin
      int            idx;
      logic [AW-1:0] base;
      logic [AW-1:0] len;
      idx           = $urandom_range(0, 3);
      base          = AW'($urandom);
      len           = AW'($urandom_range(0, 1100));
      wr_data_count = 16'($urandom_range(0, 256));
      prep_frame();
      model_bursts(base, len);
      start_frame("rand", idx, base, len);
      finish_frame("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
